pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Owns the architectural program counter and drives instruction fetch for the
//  zepto core. Presents curr_pc to pc_mux and commits pc_mux's next_pc once
//  execute signals completion. Fetches from instruction memory over a req/ack
//  handshake and hands each word to decode over a valid/ready handshake.
//  Single-issue, one instruction in flight. Provides halt control and a fetch
//  timeout error.
// PARAMETERS
//  PC_W      16      program counter / instruction address width
//  INSTR_W   16      instruction word width
//  RESET_PC  16'h0000  PC value loaded on reset
//  TIMEOUT   255     max FETCH cycles without imem_ack before error (>=1)
// PORTS
//  clk            in   1        core clock, all state on rising edge
//  rst            in   1        synchronous reset, active-high
//  curr_pc        out  PC_W     committed PC, to pc_mux curr_pc
//  next_pc        in   PC_W     from pc_mux, sampled only on commit
//  imem_req       out  1        fetch request, high throughout FETCH
//  imem_addr      out  PC_W     fetch address (= curr_pc)
//  imem_ack       in   1        memory has imem_rdata valid this cycle
//  imem_rdata     in   INSTR_W  fetched instruction word
//  instr_valid    out  1        instr/instr_pc valid to decode
//  instr_ready    in   1        decode accepts instruction
//  instr          out  INSTR_W  latched instruction word
//  instr_pc       out  PC_W     PC of latched instruction
//  exec_done      in   1        execute finished; next_pc is final
//  halt_req       in   1        request stop at next instruction boundary
//  halted         out  1        core stopped in HALT
//  fetch_err      out  1        sticky fetch timeout flag
//  retired_count  out  16       committed instruction count, wraps
// BEHAVIOUR
//  Reset: state=BOOT, curr_pc=RESET_PC, instr=0, instr_pc=0, retired_count=0,
//   tmo_cnt=0; imem_req, instr_valid, halted, fetch_err all 0. Reset at any
//   point, including mid-handshake, aborts the instruction with no commit.
//  FSM (Moore outputs, all registered/decoded from state):
//   BOOT : no outputs; -> FETCH next cycle unconditionally.
//   FETCH: imem_req=1, imem_addr=curr_pc; tmo_cnt increments each cycle.
//     imem_ack=1 -> instr<=imem_rdata, instr_pc<=curr_pc, tmo_cnt<=0, -> ISSUE.
//     else tmo_cnt==TIMEOUT-1 -> fetch_err<=1, -> ERR. ack wins on same cycle.
//   ISSUE: instr_valid=1; instr/instr_pc held stable; instr_ready=1 -> EXEC.
//   EXEC : wait for exec_done. On exec_done: curr_pc<=next_pc (no arithmetic,
//     pc_mux already wrapped mod 2^PC_W), retired_count<=retired_count+1
//     (FFFF->0000); halt_req=1 -> HALT, else -> FETCH.
//   HALT : halted=1; halt_req=0 -> FETCH (resumes at committed curr_pc).
//   ERR  : fetch_err=1 sticky; all other outputs 0; left only by rst.
//  halt_req is sampled only at EXEC commit; ignored in FETCH/ISSUE.
//  imem_ack outside FETCH, instr_ready outside ISSUE, exec_done outside EXEC
//   are ignored (no state change, no latch).
//  curr_pc changes only on EXEC commit or reset; stable for pc_mux during EXEC.
//  Minimum throughput: 3 cycles/instruction (ack, ready, done each same-cycle).
// TESTING
//  T1 reset: rst 2 cycles -> curr_pc=0000, all flags 0; cycle after BOOT
//   imem_req=1, imem_addr=0000.
//  T2 straight-line: ack with 16'hA123 -> instr_valid=1, instr=A123,
//   instr_pc=0000; ready, exec_done with next_pc=0001 -> curr_pc=0001,
//   retired_count=1, FETCH at 0001 three cycles after first req.
//  T3 branch/wrap: curr_pc=FFFF, next_pc=0000 at exec_done -> imem_addr=0000;
//   retired_count from FFFF -> 0000.
//  T4 backpressure: hold instr_ready=0 10 cycles -> instr_valid stays 1,
//   instr stable, stray exec_done pulses ignored, curr_pc unchanged.
//  T5 halt: halt_req=1 at commit with next_pc=0040 -> halted=1, no imem_req;
//   drop halt_req -> FETCH at 0040.
//  T6 timeout/reset: TIMEOUT=4, no ack -> fetch_err=1 after 4 FETCH cycles,
//   stays 1; rst -> cleared, refetch at RESET_PC; rst during ISSUE -> no commit.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter owner and single-issue fetch sequencer for the zepto core.
// Fetches over a req/ack handshake, issues to decode, commits next_pc on exec_done.
module pc_fetch_unit #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    curr_pc,
    input  logic [PC_W-1:0]    next_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               exec_done,
    input  logic               halt_req,
    output logic               halted,
    output logic               fetch_err,
    output logic [15:0]        retired_count
);
    localparam int            TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {BOOT, FETCH, ISSUE, EXEC, HALT, ERR} state_t;

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            curr_pc       <= RESET_PC;
            instr         <= '0;
            instr_pc      <= '0;
            retired_count <= '0;
            tmo_cnt       <= '0;
            fetch_err     <= 1'b0;
        end else begin
            case (state)
                BOOT:  state <= FETCH;
                FETCH: begin
                    // ack takes priority over a timeout expiring on the same cycle
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        instr_pc <= curr_pc;
                        tmo_cnt  <= '0;
                        state    <= ISSUE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ISSUE: if (instr_ready) state <= EXEC;
                EXEC: begin
                    if (exec_done) begin
                        curr_pc       <= next_pc;
                        retired_count <= retired_count + 16'd1;
                        state         <= halt_req ? HALT : FETCH;
                    end
                end
                HALT:  if (!halt_req) state <= FETCH;
                ERR:   state <= ERR;
                default: state <= BOOT;
            endcase
        end
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = curr_pc;
    assign instr_valid = (state == ISSUE);
    assign halted      = (state == HALT);
endmodule
